// File: rtl/auth_session_ctrl.sv
// auth_session_ctrl: sequences the combinational Authenticator for one card
// session. It handles account lookup, PIN checking with a per-account lockout
// mask, and inactivity timeouts. The transaction FSM is gated via session_active.
module auth_session_ctrl #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned NUM_ACCOUNTS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  acc_num_in,
  input  logic        pin_valid,
  input  logic [15:0] pin_in,
  input  logic        card_remove,
  input  logic        logout,
  input  logic        activity,
  input  logic        unlock_req,
  input  logic [3:0]  unlock_idx,
  input  logic        auth_found,
  input  logic        auth_ok,
  input  logic [3:0]  auth_index,
  output logic [3:0]  auth_acc_num,
  output logic [15:0] auth_pin,
  output logic        session_active,
  output logic [3:0]  acc_index,
  output logic [2:0]  tries_left,
  output logic        evt_auth_ok,
  output logic        evt_pin_bad,
  output logic        evt_not_found,
  output logic        evt_locked,
  output logic        evt_timeout
);

  localparam logic [2:0]  MAX_TRIES3 = 3'(MAX_TRIES);
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  NUM_ACC5   = 5'(NUM_ACCOUNTS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_PIN,
    CHECK,
    SESSION
  } state_t;

  state_t                  state;
  logic [2:0]              fail_count;
  logic [15:0]             timer;
  logic [NUM_ACCOUNTS-1:0] lock;
  logic                    lock_hit;
  logic [2:0]              fail_next;

  // Indices beyond the mask never read as locked.
  always_comb begin
    lock_hit  = 1'b0;
    if ({1'b0, auth_index} < NUM_ACC5) lock_hit = lock[auth_index];
    fail_next = fail_count + 3'd1;
  end

  assign tries_left = MAX_TRIES3 - fail_count;

  // Session FSM with registered outputs, lock mask, and inactivity timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      auth_acc_num   <= '0;
      auth_pin       <= '0;
      acc_index      <= '0;
      session_active <= 1'b0;
      fail_count     <= '0;
      timer          <= '0;
      lock           <= '0;
      evt_auth_ok    <= 1'b0;
      evt_pin_bad    <= 1'b0;
      evt_not_found  <= 1'b0;
      evt_locked     <= 1'b0;
      evt_timeout    <= 1'b0;
    end else begin
      evt_auth_ok   <= 1'b0;
      evt_pin_bad   <= 1'b0;
      evt_not_found <= 1'b0;
      evt_locked    <= 1'b0;
      evt_timeout   <= 1'b0;

      // Unlock is applied first so that a lock set later in this block wins.
      if (unlock_req && ({1'b0, unlock_idx} < NUM_ACC5)) lock[unlock_idx] <= 1'b0;

      if (card_remove && state != IDLE) begin
        state          <= IDLE;
        auth_pin       <= '0;
        session_active <= 1'b0;
        acc_index      <= '0;
        fail_count     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (card_in) begin
              auth_acc_num <= acc_num_in;
              auth_pin     <= '0;
              fail_count   <= '0;
              state        <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (!auth_found) begin
              evt_not_found <= 1'b1;
              state         <= IDLE;
              auth_pin      <= '0;
              acc_index     <= '0;
            end else if (lock_hit) begin
              evt_locked <= 1'b1;
              state      <= IDLE;
              auth_pin   <= '0;
              acc_index  <= '0;
            end else begin
              acc_index <= auth_index;
              timer     <= TIMER_LOAD;
              state     <= WAIT_PIN;
            end
          end
          WAIT_PIN: begin
            if (pin_valid) begin
              auth_pin <= pin_in;
              state    <= CHECK;
            end else if (timer == '0) begin
              evt_timeout <= 1'b1;
              state       <= IDLE;
              auth_pin    <= '0;
              acc_index   <= '0;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          CHECK: begin
            if (auth_ok) begin
              evt_auth_ok    <= 1'b1;
              timer          <= TIMER_LOAD;
              session_active <= 1'b1;
              state          <= SESSION;
            end else if (fail_next >= MAX_TRIES3) begin
              fail_count <= MAX_TRIES3;
              if ({1'b0, acc_index} < NUM_ACC5) lock[acc_index] <= 1'b1;
              evt_locked <= 1'b1;
              state      <= IDLE;
              auth_pin   <= '0;
              acc_index  <= '0;
            end else begin
              fail_count  <= fail_next;
              evt_pin_bad <= 1'b1;
              timer       <= TIMER_LOAD;
              state       <= WAIT_PIN;
            end
          end
          SESSION: begin
            if (logout) begin
              state          <= IDLE;
              auth_pin       <= '0;
              session_active <= 1'b0;
              acc_index      <= '0;
            end else if (activity) begin
              timer <= TIMER_LOAD;
            end else if (timer == '0) begin
              evt_timeout    <= 1'b1;
              state          <= IDLE;
              auth_pin       <= '0;
              session_active <= 1'b0;
              acc_index      <= '0;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_session_ctrl.sv
// Directed bench for auth_session_ctrl with a small Authenticator stand-in:
// account numbers 1..10 map to indices 0..9. The PIN for index 0 is 1234,
// for index 2 it is 3456, and for any other index it is 5000+index.
module tb_auth_session_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in;
  logic [3:0]  acc_num_in;
  logic        pin_valid;
  logic [15:0] pin_in;
  logic        card_remove;
  logic        logout;
  logic        activity;
  logic        unlock_req;
  logic [3:0]  unlock_idx;
  logic        auth_found;
  logic        auth_ok;
  logic [3:0]  auth_index;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic        session_active;
  logic [3:0]  acc_index;
  logic [2:0]  tries_left;
  logic        evt_auth_ok, evt_pin_bad, evt_not_found, evt_locked, evt_timeout;
  logic [4:0]  evts;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // evts order: {auth_ok, pin_bad, not_found, locked, timeout}
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_OK   = 5'b10000;
  localparam logic [4:0] E_BAD  = 5'b01000;
  localparam logic [4:0] E_NF   = 5'b00100;
  localparam logic [4:0] E_LOCK = 5'b00010;
  localparam logic [4:0] E_TO   = 5'b00001;

  auth_session_ctrl #(
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (8),
    .NUM_ACCOUNTS   (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .acc_num_in     (acc_num_in),
    .pin_valid      (pin_valid),
    .pin_in         (pin_in),
    .card_remove    (card_remove),
    .logout         (logout),
    .activity       (activity),
    .unlock_req     (unlock_req),
    .unlock_idx     (unlock_idx),
    .auth_found     (auth_found),
    .auth_ok        (auth_ok),
    .auth_index     (auth_index),
    .auth_acc_num   (auth_acc_num),
    .auth_pin       (auth_pin),
    .session_active (session_active),
    .acc_index      (acc_index),
    .tries_left     (tries_left),
    .evt_auth_ok    (evt_auth_ok),
    .evt_pin_bad    (evt_pin_bad),
    .evt_not_found  (evt_not_found),
    .evt_locked     (evt_locked),
    .evt_timeout    (evt_timeout)
  );

  always #5 clk = ~clk;

  assign evts = {evt_auth_ok, evt_pin_bad, evt_not_found, evt_locked, evt_timeout};

  function automatic logic [15:0] pin_of(input logic [3:0] idx);
    if (idx == 4'd0) return 16'd1234;
    if (idx == 4'd2) return 16'd3456;
    return 16'd5000 + 16'(idx);
  endfunction

  // Combinational Authenticator stand-in.
  always_comb begin
    auth_found = (auth_acc_num >= 4'd1) && (auth_acc_num <= 4'd10);
    auth_index = auth_found ? auth_acc_num - 4'd1 : 4'd0;
    auth_ok    = auth_found && (auth_pin == pin_of(auth_index));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Card insertion followed by the LOOKUP cycle; outputs reflect the lookup result.
  task automatic insert(input logic [3:0] acc);
    card_in = 1'b1; acc_num_in = acc;
    step();
    card_in = 1'b0;
    step();
  endtask

  // PIN entry followed by the CHECK cycle; outputs reflect the check result.
  task automatic enter_pin(input logic [15:0] p);
    pin_valid = 1'b1; pin_in = p;
    step();
    pin_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; card_in = 1'b0; acc_num_in = '0; pin_valid = 1'b0; pin_in = '0;
    card_remove = 1'b0; logout = 1'b0; activity = 1'b0; unlock_req = 1'b0; unlock_idx = '0;
    steps(2);
    rst = 1'b0;
    check("rst_session", 32'(session_active), 32'd0);
    check("rst_tries", 32'(tries_left), 32'd3);
    check("rst_evts", 32'(evts), 32'(E_NONE));
    check("rst_acc_num", 32'(auth_acc_num), 32'd0);
    check("rst_pin", 32'(auth_pin), 32'd0);

    // Good login on account 1, then logout.
    insert(4'd1);
    check("good_lookup_evts", 32'(evts), 32'(E_NONE));
    check("good_acc_num", 32'(auth_acc_num), 32'd1);
    pin_valid = 1'b1; pin_in = 16'd1234;
    step();
    pin_valid = 1'b0;
    check("good_check_pin", 32'(auth_pin), 32'd1234);
    check("good_check_evts", 32'(evts), 32'(E_NONE));
    step();
    check("good_evts", 32'(evts), 32'(E_OK));
    check("good_session", 32'(session_active), 32'd1);
    check("good_index", 32'(acc_index), 32'd0);
    step();
    check("good_pulse_width", 32'(evts), 32'(E_NONE));
    logout = 1'b1; step(); logout = 1'b0;
    check("logout_session", 32'(session_active), 32'd0);
    check("logout_pin_clr", 32'(auth_pin), 32'd0);

    // Unknown account.
    insert(4'd12);
    check("nf_evts", 32'(evts), 32'(E_NF));
    check("nf_session", 32'(session_active), 32'd0);
    step();
    check("nf_pulse_width", 32'(evts), 32'(E_NONE));

    // Lockout of account 3 (index 2).
    insert(4'd3);
    check("lk_tries0", 32'(tries_left), 32'd3);
    enter_pin(16'd1111);
    check("lk_bad1", 32'(evts), 32'(E_BAD));
    check("lk_tries1", 32'(tries_left), 32'd2);
    enter_pin(16'd1111);
    check("lk_bad2", 32'(evts), 32'(E_BAD));
    check("lk_tries2", 32'(tries_left), 32'd1);
    enter_pin(16'd1111);
    check("lk_locked", 32'(evts), 32'(E_LOCK));
    check("lk_tries3", 32'(tries_left), 32'd0);
    check("lk_session", 32'(session_active), 32'd0);
    insert(4'd3);
    check("lk_relookup", 32'(evts), 32'(E_LOCK));
    check("lk_reinsert_tries", 32'(tries_left), 32'd3);
    enter_pin(16'd3456);
    check("lk_pin_ignored", 32'(session_active), 32'd0);
    unlock_req = 1'b1; unlock_idx = 4'd2; step(); unlock_req = 1'b0;
    insert(4'd3);
    check("ul_lookup", 32'(evts), 32'(E_NONE));
    enter_pin(16'd3456);
    check("ul_auth", 32'(evts), 32'(E_OK));
    check("ul_index", 32'(acc_index), 32'd2);
    logout = 1'b1; step(); logout = 1'b0;

    // WAIT_PIN timeout: eight cycles after entering WAIT_PIN.
    insert(4'd1);
    steps(7);
    check("to_pin_early", 32'(evts), 32'(E_NONE));
    step();
    check("to_pin_evts", 32'(evts), 32'(E_TO));
    step();
    check("to_pin_width", 32'(evts), 32'(E_NONE));

    // SESSION held by activity, then timeout.
    insert(4'd1);
    enter_pin(16'd1234);
    for (int unsigned r = 0; r < 3; r++) begin
      steps(4);
      activity = 1'b1; step(); activity = 1'b0;
      check("act_hold_session", 32'(session_active), 32'd1);
      check("act_hold_evts", 32'(evts), 32'(E_NONE));
    end
    steps(7);
    check("act_to_early", 32'(session_active), 32'd1);
    step();
    check("act_to_evts", 32'(evts), 32'(E_TO));
    check("act_to_session", 32'(session_active), 32'd0);

    // Abort during WAIT_PIN after one bad PIN.
    insert(4'd1);
    enter_pin(16'd1111);
    check("ab_bad", 32'(tries_left), 32'd2);
    card_remove = 1'b1; step(); card_remove = 1'b0;
    check("ab_evts", 32'(evts), 32'(E_NONE));
    check("ab_tries", 32'(tries_left), 32'd3);
    check("ab_pin_clr", 32'(auth_pin), 32'd0);
    insert(4'd1);
    check("ab_reinsert_tries", 32'(tries_left), 32'd3);
    enter_pin(16'd1234);
    check("ab_relogin", 32'(evts), 32'(E_OK));

    // Logout coinciding with SESSION expiry wins.
    steps(7);
    logout = 1'b1; step(); logout = 1'b0;
    check("col_evts", 32'(evts), 32'(E_NONE));
    check("col_session", 32'(session_active), 32'd0);
    step();
    check("col_after", 32'(evts), 32'(E_NONE));

    // Lock account 5 (index 4), then reset mid-session clears everything.
    insert(4'd5);
    enter_pin(16'd1);
    enter_pin(16'd1);
    enter_pin(16'd1);
    check("rs_locked", 32'(evts), 32'(E_LOCK));
    insert(4'd1);
    enter_pin(16'd1234);
    check("rs_in_session", 32'(session_active), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rs_session", 32'(session_active), 32'd0);
    check("rs_index", 32'(acc_index), 32'd0);
    check("rs_acc_num", 32'(auth_acc_num), 32'd0);
    check("rs_pin", 32'(auth_pin), 32'd0);
    check("rs_tries", 32'(tries_left), 32'd3);
    check("rs_evts", 32'(evts), 32'(E_NONE));
    insert(4'd5);
    check("rs_lock_cleared", 32'(evts), 32'(E_NONE));
    enter_pin(16'd5004);
    check("rs_auth5", 32'(evts), 32'(E_OK));
    check("rs_index5", 32'(acc_index), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
